// File: rtl/serial_rx_8b_pkg.sv
// Shared definitions for the single-wire serial link receiver.
// Holds the FSM state encodings, the line idle level and the default sizes.
package serial_rx_8b_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam int   DEF_OVS    = 4;
  localparam int   DEF_DATA_W = 8;
  localparam int   DEF_SYNC   = 2;

endpackage

// File: rtl/serial_rx_8b_sync_2ff.sv
// Multi-flop synchroniser for the asynchronous serial line.
// Ports: clk, rst (async, active high), d (async in), q (synchronised out).
// The flops reset to the line idle level so no false start follows reset.
module sync_2ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= {STAGES{RST_VAL}};
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/serial_rx_8b.sv
// Serial link receiver: oversampled UART-style framing, LSB first.
// Ports: CLK, RST (async, active high), I (serial line, idle high),
//   DOUT (last good word), VALID/ERR/PERR (1-cycle pulses), BUSY.
// Optional even parity bit enabled by defining SERIAL_RX_PARITY_EN;
// without it PERR is tied 0 and the frame carries no parity bit.
module serial_rx_8b
  import serial_rx_8b_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OVS         = DEF_OVS,
  parameter int SYNC_STAGES = DEF_SYNC
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I,
  output logic [DATA_W-1:0] DOUT,
  output logic              VALID,
  output logic              ERR,
  output logic              PERR,
  output logic              BUSY
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic s_i;

  sync_2ff #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(LINE_IDLE)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (I),
    .q  (s_i)
  );

  rx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] dout_d;
  logic              valid_d, err_d;
  logic              busy_d;
  logic              armed_q, armed_d;

`ifdef SERIAL_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_d;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      DOUT    <= '0;
      VALID   <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      DOUT    <= dout_d;
      VALID   <= valid_d;
      ERR     <= err_d;
      BUSY    <= busy_d;
      armed_q <= armed_d;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_bad_q <= 1'b0;
      PERR      <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      PERR      <= perr_d;
    end
  end
`else
  assign PERR = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dout_d  = DOUT;
    valid_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = BUSY;
    armed_d = armed_q;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // A start edge only counts once the line has been seen idle.
        if (s_i) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!s_i) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_END) begin
          cnt_d = '0;
          sh_d  = {s_i, sh_q[DATA_W-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_END) begin
          cnt_d     = '0;
          par_bad_d = s_i ^ (^sh_q);
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          // A high stop bit arms the next start immediately.
          armed_d = s_i;
          if (s_i) begin
            dout_d  = sh_q;
            valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_rx_8b.sv
// Directed testbench for serial_rx_8b (OVS=4, DATA_W=8, SYNC_STAGES=2).
// Define SERIAL_RX_PARITY_EN for both RTL and bench to exercise parity.
module tb_serial_rx_8b;

`ifdef SERIAL_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 2 + 2 + (8 + 1 + P) * 4 + 1;

  logic       CLK;
  logic       RST;
  logic       I;
  logic [7:0] DOUT;
  logic       VALID;
  logic       ERR;
  logic       PERR;
  logic       BUSY;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int k;

  int         vc[$];
  logic [7:0] vd[$];
  logic       vp[$];
  int         ec[$];

  serial_rx_8b #(
    .DATA_W     (8),
    .OVS        (4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .I    (I),
    .DOUT (DOUT),
    .VALID(VALID),
    .ERR  (ERR),
    .PERR (PERR),
    .BUSY (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (VALID) begin
      vc.push_back(cyc);
      vd.push_back(DOUT);
      vp.push_back(PERR);
    end
    if (ERR) ec.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    vc.delete();
    vd.delete();
    vp.delete();
    ec.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic par,
                      input logic stop);
    I = 1'b0;
    tick(4);
    for (int b = 0; b < 8; b++) begin
      I = d[b];
      tick(4);
    end
`ifdef SERIAL_RX_PARITY_EN
    I = par;
    tick(4);
`else
    if (par) I = 1'b1;
`endif
    I = stop;
    tick(4);
  endtask

  initial begin
    RST = 1'b1;
    I   = 1'b1;
    tick(3);
    chk("rst_dout", DOUT, 8'h00);
    chk("rst_valid", VALID, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_perr", PERR, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    RST = 1'b0;
    tick(4);

    // Single good frame
    clr();
    k = cyc;
    send(8'hA5, 1'b0, 1'b1);
    tick(3);
    chk("a5_nvalid", vc.size(), 1);
    chk("a5_cycle", vc[0] - k, LAT);
    chk("a5_dout", vd[0], 8'hA5);
    chk("a5_nerr", ec.size(), 0);
    chk("a5_busy", BUSY, 1'b0);
    tick(4);

    // One-cycle glitch
    clr();
    k = cyc;
    I = 1'b0;
    tick(1);
    I = 1'b1;
    tick(5);
    chk("gl_busy", BUSY, 1'b0);
    tick(45);
    chk("gl_nvalid", vc.size(), 0);
    chk("gl_nerr", ec.size(), 0);
    chk("gl_dout", DOUT, 8'hA5);

    // Framing error, line held low afterwards
    clr();
    k = cyc;
    send(8'h5A, 1'b0, 1'b0);
    tick(12);
    chk("fe_nerr", ec.size(), 1);
    chk("fe_cycle", ec[0] - k, LAT);
    chk("fe_nvalid", vc.size(), 0);
    chk("fe_dout", DOUT, 8'hA5);
    chk("fe_busy", BUSY, 1'b0);
    I = 1'b1;
    tick(4);
    clr();
    k = cyc;
    send(8'h11, 1'b0, 1'b1);
    tick(3);
    chk("r11_nvalid", vc.size(), 1);
    chk("r11_cycle", vc[0] - k, LAT);
    chk("r11_dout", vd[0], 8'h11);
    tick(4);

    // Back-to-back frames
    clr();
    k = cyc;
    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    tick(3);
    chk("bb_nvalid", vc.size(), 2);
    chk("bb_cyc0", vc[0] - k, LAT);
    chk("bb_gap", vc[1] - vc[0], LAT - 1);
    chk("bb_d0", vd[0], 8'h00);
    chk("bb_d1", vd[1], 8'hFF);
    chk("bb_nerr", ec.size(), 0);
    tick(4);

    // Reset in the middle of data bit 3
    clr();
    I = 1'b0;
    tick(4);
    I = 1'b1;
    tick(4);
    I = 1'b0;
    tick(4);
    I = 1'b1;
    tick(4);
    I = 1'b1;
    tick(2);
    chk("mr_busy_pre", BUSY, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    chk("mr_dout", DOUT, 8'h00);
    chk("mr_busy", BUSY, 1'b0);
    chk("mr_valid", VALID, 1'b0);
    I = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(4);
    chk("mr_nvalid", vc.size(), 0);
    clr();
    k = cyc;
    send(8'h3C, 1'b0, 1'b1);
    tick(3);
    chk("r3c_nvalid", vc.size(), 1);
    chk("r3c_dout", vd[0], 8'h3C);
    tick(4);

`ifdef SERIAL_RX_PARITY_EN
    // 0x01 has one set bit, so parity bit 0 is wrong
    clr();
    send(8'h01, 1'b0, 1'b1);
    tick(3);
    chk("p01_nvalid", vc.size(), 1);
    chk("p01_dout", vd[0], 8'h01);
    chk("p01_perr", vp[0], 1'b1);
    tick(4);
    clr();
    send(8'h03, 1'b0, 1'b1);
    tick(3);
    chk("p03_nvalid", vc.size(), 1);
    chk("p03_dout", vd[0], 8'h03);
    chk("p03_perr", vp[0], 1'b0);
`else
    chk("np_perr", PERR, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
